mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register and writeback unit of the RV32I core. Captures the

---
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register and writeback unit of the RV32I core.
// Captures the memory-stage result, aligns and extends load data, selects the
// writeback value and drives the register file write port. The stage valid bit
// and a retired-instruction counter are exported for the hazard unit and CSRs.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [1:0]            in_result_src,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_read_data,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  output logic                  wb_write_enable,
  output logic [ADDR_WIDTH-1:0] wb_write_addr,
  output logic [DATA_WIDTH-1:0] wb_write_data,
  output logic                  wb_valid,
  output logic [31:0]           instret
);

  // Writeback source select as encoded by the decoder.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_NONE = 2'b11
  } result_src_e;

  // Load size/sign encodings (funct3 of the LOAD opcode).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Everything the stage holds for one instruction.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] rd;
    result_src_e           result_src;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } stage_t;

  stage_t                stage_q;
  stage_t                stage_d;
  logic [31:0]           instret_q;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  retire;

  // An instruction leaves the stage on any edge where it is valid and not held;
  // a flush on the same edge still lets the departing instruction count.
  assign retire = stage_q.valid & ~stall;

  // Pack the MEM-stage inputs into the stage record.
  always_comb begin
    stage_d            = stage_q;
    stage_d.valid      = in_valid;
    stage_d.reg_write  = in_reg_write;
    stage_d.rd         = in_rd;
    stage_d.result_src = result_src_e'(in_result_src);
    stage_d.funct3     = in_funct3;
    stage_d.alu_result = in_alu_result;
    stage_d.read_data  = in_read_data;
    stage_d.pc_plus4   = in_pc_plus4;
  end

  // Pipeline register: flush inserts a bubble, stall holds, otherwise capture.
  // NOTE: sequential state is written with <= so every flop samples the values
  // from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q.valid <= 1'b0;
    end else if (!stall) begin
      stage_q <= stage_d;
    end
  end

  // Retired-instruction counter; wraps silently at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  // Pick the addressed byte and halfword out of the raw memory word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statements can leave it unassigned and infer a latch.
    load_byte = stage_q.read_data[7:0];
    load_half = stage_q.read_data[15:0];
    case (stage_q.alu_result[1:0])
      2'd0:    load_byte = stage_q.read_data[7:0];
      2'd1:    load_byte = stage_q.read_data[15:8];
      2'd2:    load_byte = stage_q.read_data[23:16];
      default: load_byte = stage_q.read_data[31:24];
    endcase
    // Halfword selection uses address bit 1 only; bit 0 is ignored.
    if (stage_q.alu_result[1]) begin
      load_half = stage_q.read_data[31:16];
    end
  end

  // Sign- or zero-extend the selected load lane; words pass through untouched.
  always_comb begin
    load_data = stage_q.read_data;
    case (stage_q.funct3)
      F3_LB:   load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      F3_LH:   load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_data = stage_q.read_data;
    endcase
  end

  // Writeback value mux; the reserved encoding writes zero.
  always_comb begin
    wb_write_data = '0;
    case (stage_q.result_src)
      SRC_ALU:  wb_write_data = stage_q.alu_result;
      SRC_LOAD: wb_write_data = load_data;
      SRC_PC4:  wb_write_data = stage_q.pc_plus4;
      SRC_NONE: wb_write_data = '0;
      default:  wb_write_data = '0;
    endcase
  end

  // Register file port is driven straight from the stage registers, so a
  // stalled instruction keeps re-writing the same value, which is harmless.
  // x0 is hard-wired to zero and is never written.
  assign wb_write_enable = stage_q.valid & stage_q.reg_write & (stage_q.rd != '0);
  assign wb_write_addr   = stage_q.rd;
  assign wb_valid        = stage_q.valid;
  assign instret         = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Self-checking bench for mem_wb_stage: directed table, multi-cycle corner
// sequences and randomized traffic against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } instr_t;

  typedef struct packed {
    instr_t      in;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_result_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_read_data;
  logic [31:0] in_pc_plus4;
  logic        wb_write_enable;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        wb_valid;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  // Reference model state: the instruction the stage should hold and the count.
  instr_t      m_held;
  logic [31:0] m_count;

  mem_wb_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_reg_write    (in_reg_write),
    .in_rd           (in_rd),
    .in_result_src   (in_result_src),
    .in_funct3       (in_funct3),
    .in_alu_result   (in_alu_result),
    .in_read_data    (in_read_data),
    .in_pc_plus4     (in_pc_plus4),
    .wb_write_enable (wb_write_enable),
    .wb_write_addr   (wb_write_addr),
    .wb_write_data   (wb_write_data),
    .wb_valid        (wb_valid),
    .instret         (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic rw, input logic [4:0] rd,
                                input logic [1:0] src, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rdata,
                                input logic [31:0] pc4);
    instr_t i;
    i.valid = v; i.reg_write = rw; i.rd = rd; i.src = src; i.f3 = f3;
    i.alu = alu; i.rdata = rdata; i.pc4 = pc4;
    return i;
  endfunction

  // Load value from the RISC-V rules, computed with shifts and arithmetic.
  function automatic logic [31:0] model_load(input instr_t i);
    int unsigned byte_v;
    int unsigned half_v;
    byte_v = (i.rdata >> (8 * i.alu[1:0])) & 32'hFF;
    half_v = (i.rdata >> (16 * i.alu[1])) & 32'hFFFF;
    case (i.f3)
      3'b000:  return (byte_v >= 128) ? byte_v - 256 : byte_v;
      3'b100:  return byte_v;
      3'b001:  return (half_v >= 32768) ? half_v - 65536 : half_v;
      3'b101:  return half_v;
      default: return i.rdata;
    endcase
  endfunction

  function automatic logic [31:0] model_data(input instr_t i);
    case (i.src)
      2'd0:    return i.alu;
      2'd1:    return model_load(i);
      2'd2:    return i.pc4;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic cycle(input instr_t in, input logic st, input logic fl);
    in_valid      = in.valid;
    in_reg_write  = in.reg_write;
    in_rd         = in.rd;
    in_result_src = in.src;
    in_funct3     = in.f3;
    in_alu_result = in.alu;
    in_read_data  = in.rdata;
    in_pc_plus4   = in.pc4;
    stall         = st;
    flush         = fl;
    @(posedge clk);
    if (m_held.valid && !st) m_count = m_count + 32'd1;
    if (fl) m_held.valid = 1'b0;
    else if (!st) m_held = in;
    #1;
  endtask

  // Compare all outputs against the model; address/data matter only when valid.
  task automatic check_model(input string tag);
    check({tag, "_valid"}, {31'd0, wb_valid}, {31'd0, m_held.valid});
    check({tag, "_we"}, {31'd0, wb_write_enable},
          {31'd0, m_held.valid && m_held.reg_write && (m_held.rd != 5'd0)});
    check({tag, "_instret"}, instret, m_count);
    if (m_held.valid) begin
      check({tag, "_addr"}, {27'd0, wb_write_addr}, {27'd0, m_held.rd});
      check({tag, "_data"}, wb_write_data, model_data(m_held));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_we"}, {31'd0, wb_write_enable}, 32'd0);
    check({tag, "_addr"}, {27'd0, wb_write_addr}, 32'd0);
    check({tag, "_data"}, wb_write_data, 32'd0);
    check({tag, "_instret"}, instret, 32'd0);
  endtask

  vec_t        vecs [15];
  instr_t      a_ins;
  instr_t      b_ins;
  logic [31:0] cnt0;

  initial begin
    m_held  = '0;
    m_count = '0;
    reset   = 1'b1;
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    m_held  = '0;
    m_count = '0;
    check_zero("reset");
    #2 reset = 1'b0;

    // Directed table: {instruction, expected WE, address, data}.
    vecs[0]  = '{mk(1, 1, 5, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0), 1'b1, 5'd5, 32'h0000_1234};
    vecs[1]  = '{mk(1, 1, 7, 2'd1, 3'd0, 32'h0000_0003, 32'h80FF_0000, 32'h0), 1'b1, 5'd7, 32'hFFFF_FF80};
    vecs[2]  = '{mk(1, 1, 7, 2'd1, 3'd4, 32'h0000_0003, 32'h80FF_0000, 32'h0), 1'b1, 5'd7, 32'h0000_0080};
    vecs[3]  = '{mk(1, 1, 8, 2'd1, 3'd1, 32'h0000_0002, 32'h80FF_0000, 32'h0), 1'b1, 5'd8, 32'hFFFF_80FF};
    vecs[4]  = '{mk(1, 1, 8, 2'd1, 3'd1, 32'h0000_0003, 32'h80FF_0000, 32'h0), 1'b1, 5'd8, 32'hFFFF_80FF};
    vecs[5]  = '{mk(1, 1, 8, 2'd1, 3'd5, 32'h0000_0002, 32'h80FF_0000, 32'h0), 1'b1, 5'd8, 32'h0000_80FF};
    vecs[6]  = '{mk(1, 1, 9, 2'd1, 3'd2, 32'h0000_0000, 32'h80FF_0000, 32'h0), 1'b1, 5'd9, 32'h80FF_0000};
    vecs[7]  = '{mk(1, 1, 9, 2'd1, 3'd3, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0), 1'b1, 5'd9, 32'hDEAD_BEEF};
    vecs[8]  = '{mk(1, 1, 10, 2'd1, 3'd0, 32'h0000_0000, 32'h1234_567F, 32'h0), 1'b1, 5'd10, 32'h0000_007F};
    vecs[9]  = '{mk(1, 1, 10, 2'd1, 3'd0, 32'h0000_0001, 32'h1234_5680, 32'h0), 1'b1, 5'd10, 32'h0000_0056};
    vecs[10] = '{mk(1, 1, 11, 2'd1, 3'd5, 32'h0000_0000, 32'h1234_F678, 32'h0), 1'b1, 5'd11, 32'h0000_F678};
    vecs[11] = '{mk(1, 1, 0, 2'd0, 3'd0, 32'h0000_5555, 32'h0, 32'h0), 1'b0, 5'd0, 32'h0000_5555};
    vecs[12] = '{mk(1, 1, 1, 2'd2, 3'd0, 32'h0000_0000, 32'h0, 32'h0000_0104), 1'b1, 5'd1, 32'h0000_0104};
    vecs[13] = '{mk(1, 1, 2, 2'd3, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 5'd2, 32'h0};
    vecs[14] = '{mk(1, 0, 3, 2'd0, 3'd0, 32'h0000_0042, 32'h0, 32'h0), 1'b0, 5'd3, 32'h0000_0042};

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].in, 1'b0, 1'b0);
      check($sformatf("tbl%0d_we", i), {31'd0, wb_write_enable}, {31'd0, vecs[i].we});
      check($sformatf("tbl%0d_addr", i), {27'd0, wb_write_addr}, {27'd0, vecs[i].addr});
      check($sformatf("tbl%0d_data", i), wb_write_data, vecs[i].data);
      check($sformatf("tbl%0d_instret", i), instret, i);
    end

    // Async reset in the middle of a cycle clears everything immediately.
    #2 reset = 1'b1;
    #1;
    m_held  = '0;
    m_count = '0;
    check_zero("async_rst");
    @(posedge clk);
    #3 reset = 1'b0;

    // Stall for three cycles: port keeps writing the same values, no count.
    a_ins = mk(1, 1, 9, 2'd0, 3'd0, 32'h0000_AAAA, 32'h0, 32'h0);
    b_ins = mk(1, 1, 12, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0200);
    cycle(a_ins, 1'b0, 1'b0);
    cnt0 = m_count;
    for (int i = 0; i < 3; i++) begin
      cycle(b_ins, 1'b1, 1'b0);
      check("stall_we", {31'd0, wb_write_enable}, 32'd1);
      check("stall_addr", {27'd0, wb_write_addr}, 32'd9);
      check("stall_data", wb_write_data, 32'h0000_AAAA);
      check("stall_instret", instret, cnt0);
    end
    cycle(b_ins, 1'b0, 1'b0);
    check("release_instret", instret, cnt0 + 32'd1);
    check("release_data", wb_write_data, 32'h0000_0200);

    // Stall and flush together: bubble, and the stalled instruction does not retire.
    cnt0 = m_count;
    cycle(a_ins, 1'b1, 1'b1);
    check("stflush_valid", {31'd0, wb_valid}, 32'd0);
    check("stflush_we", {31'd0, wb_write_enable}, 32'd0);
    check("stflush_instret", instret, cnt0);
    cycle(a_ins, 1'b0, 1'b0);
    check("bubble_no_count", instret, cnt0);
    // Flush alone still counts the departing instruction.
    cycle(b_ins, 1'b0, 1'b1);
    check("flush_we", {31'd0, wb_write_enable}, 32'd0);
    check("flush_instret", instret, cnt0 + 32'd1);
    check_model("flush");

    // Counter wrap: preload all-ones, then one more retire goes to zero.
    cycle(a_ins, 1'b0, 1'b0);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    m_count = 32'hFFFF_FFFF;
    check("wrap_preload", instret, 32'hFFFF_FFFF);
    cycle(b_ins, 1'b0, 1'b0);
    check("wrap_zero", instret, 32'h0);
    cycle(b_ins, 1'b0, 1'b0);
    check("wrap_one", instret, 32'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      instr_t r;
      r.valid     = ($urandom_range(0, 3) != 0);
      r.reg_write = ($urandom_range(0, 4) != 0);
      r.rd        = 5'($urandom_range(0, 31));
      r.src       = 2'($urandom_range(0, 3));
      r.f3        = 3'($urandom_range(0, 7));
      r.alu       = $urandom;
      r.rdata     = $urandom;
      r.pc4       = $urandom;
      cycle(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
